// File: rtl/issue_scoreboard_if.sv
// Decode-to-issue handshake bundle for the dual-issue scoreboard.
// The master side (decode) presents the instruction pair and the flush/stall
// controls. The slave side (scoreboard) returns the issue decisions and the
// per-register busy vector.
interface issue_scoreboard_if #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int LAT_W = 3
);
  logic             flush_i;
  logic             stall_i;

  logic             inst1_valid_i;
  logic             inst1_re1_i;
  logic [AW-1:0]    inst1_raddr1_i;
  logic             inst1_re2_i;
  logic [AW-1:0]    inst1_raddr2_i;
  logic             inst1_we_i;
  logic [AW-1:0]    inst1_waddr_i;
  logic [LAT_W-1:0] inst1_lat_i;
  logic             inst1_mem_i;
  logic             inst1_solo_i;

  logic             inst2_valid_i;
  logic             inst2_re1_i;
  logic [AW-1:0]    inst2_raddr1_i;
  logic             inst2_re2_i;
  logic [AW-1:0]    inst2_raddr2_i;
  logic             inst2_we_i;
  logic [AW-1:0]    inst2_waddr_i;
  logic [LAT_W-1:0] inst2_lat_i;
  logic             inst2_mem_i;
  logic             inst2_solo_i;

  logic             issue1_o;
  logic             issue2_o;
  logic [NREG-1:0]  busy_o;

  modport master (
    output flush_i, stall_i,
    output inst1_valid_i, inst1_re1_i, inst1_raddr1_i, inst1_re2_i, inst1_raddr2_i,
    output inst1_we_i, inst1_waddr_i, inst1_lat_i, inst1_mem_i, inst1_solo_i,
    output inst2_valid_i, inst2_re1_i, inst2_raddr1_i, inst2_re2_i, inst2_raddr2_i,
    output inst2_we_i, inst2_waddr_i, inst2_lat_i, inst2_mem_i, inst2_solo_i,
    input  issue1_o, issue2_o, busy_o
  );

  modport slave (
    input  flush_i, stall_i,
    input  inst1_valid_i, inst1_re1_i, inst1_raddr1_i, inst1_re2_i, inst1_raddr2_i,
    input  inst1_we_i, inst1_waddr_i, inst1_lat_i, inst1_mem_i, inst1_solo_i,
    input  inst2_valid_i, inst2_re1_i, inst2_raddr1_i, inst2_re2_i, inst2_raddr2_i,
    input  inst2_we_i, inst2_waddr_i, inst2_lat_i, inst2_mem_i, inst2_solo_i,
    output issue1_o, issue2_o, busy_o
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Dual-issue scoreboard between decode and issue.
// Each architectural register has a countdown of cycles until its in-flight
// result becomes bypassable. From these counters, each cycle decides whether
// the decode pair issues dual, issues slot 1 only, or stalls.
// Register 0 is hard-wired and never busy.
module issue_scoreboard #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  issue_scoreboard_if.slave sb
);

  logic [LAT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  busy;
  logic             issue1;
  logic             issue2;
  logic             s1_ok;
  logic             s2_ok;
  logic             raw_pair;
  logic             pair_ok;

  // A source is ready if it is not read, is r0, or its counter has expired.
  function automatic logic src_ok(input logic re, input logic [AW-1:0] a,
                                  input logic [LAT_W-1:0] c);
    return !re || (a == '0) || (c == '0);
  endfunction

  // Issue decision: slot 1 first; slot 2 only alongside slot 1 (in order).
  always_comb begin
    s1_ok    = 1'b0;
    s2_ok    = 1'b0;
    raw_pair = 1'b0;
    pair_ok  = 1'b0;
    issue1   = 1'b0;
    issue2   = 1'b0;

    s1_ok = src_ok(sb.inst1_re1_i, sb.inst1_raddr1_i, cnt[sb.inst1_raddr1_i]) &&
            src_ok(sb.inst1_re2_i, sb.inst1_raddr2_i, cnt[sb.inst1_raddr2_i]);
    s2_ok = src_ok(sb.inst2_re1_i, sb.inst2_raddr1_i, cnt[sb.inst2_raddr1_i]) &&
            src_ok(sb.inst2_re2_i, sb.inst2_raddr2_i, cnt[sb.inst2_raddr2_i]);

    // Slot 2 consuming slot 1's result cannot issue in the same cycle.
    raw_pair = sb.inst1_we_i && (sb.inst1_waddr_i != '0) &&
               ((sb.inst2_re1_i && (sb.inst2_raddr1_i == sb.inst1_waddr_i)) ||
                (sb.inst2_re2_i && (sb.inst2_raddr2_i == sb.inst1_waddr_i)));

    // Only one memory port, and serialising instructions go alone.
    pair_ok = !sb.inst1_solo_i && !sb.inst2_solo_i &&
              !(sb.inst1_mem_i && sb.inst2_mem_i) && !raw_pair;

    issue1 = !rst && !sb.flush_i && !sb.stall_i && sb.inst1_valid_i && s1_ok;
    issue2 = issue1 && sb.inst2_valid_i && s2_ok && pair_ok;
  end

  // Busy vector is a direct view of the counters.
  always_comb begin
    busy = '0;
    for (int r = 0; r < NREG; r++) begin
      busy[r] = (cnt[r] != '0);
    end
  end

  assign sb.issue1_o = issue1;
  assign sb.issue2_o = issue2;
  assign sb.busy_o   = busy;

  // Counter update: slot 2 wins WAW (younger), r0 never loaded, countdown saturates at 0.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (rst || sb.flush_i) begin
        cnt[r] <= '0;
      end else if ((r != 0) && issue2 && sb.inst2_we_i && (sb.inst2_waddr_i == AW'(r))) begin
        cnt[r] <= sb.inst2_lat_i - 1'b1;
      end else if ((r != 0) && issue1 && sb.inst1_we_i && (sb.inst1_waddr_i == AW'(r))) begin
        cnt[r] <= sb.inst1_lat_i - 1'b1;
      end else if (cnt[r] != '0) begin
        cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

endmodule
